// File: rtl/cim_seq_pkg.sv
// cim_seq_pkg: FSM state encoding and counter-width helpers shared by the CiM operator sequencer
package cim_seq_pkg;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_WAIT_A  = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_RESULT  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int plane_w(input int act_w);
        return cnt_w(act_w);
    endfunction

    function automatic int row_w(input int rows);
        return cnt_w(rows);
    endfunction
endpackage

// File: rtl/dff.sv
// dff: enable-gated register bank with asynchronous active-low clear
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) q_o <= '0;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/cim_op_seq.sv
// cim_op_seq: sequences one ternary matrix-vector operator on the CiM macro,
// loading weight rows, streaming activation bit-planes MSB first and handing off results.
module cim_op_seq
    import cim_seq_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int ACT_W   = 8,
    parameter int MAC_LAT = 2,
    parameter int NVEC_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic                      reload_w_i,
    input  logic [NVEC_W-1:0]         cfg_nvec_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [2*COLS-1:0]         w_data_i,
    output logic [ROWS-1:0]           wrow_en_o,
    output logic [2*COLS-1:0]         wrow_data_o,
    input  logic                      a_valid_i,
    output logic                      a_ready_o,
    input  logic [ROWS*ACT_W-1:0]     a_data_i,
    output logic                      cim_en_o,
    output logic [ROWS-1:0]           a_bit_o,
    output logic [plane_w(ACT_W)-1:0] plane_o,
    output logic                      acc_clr_o,
    output logic                      acc_neg_o,
    output logic                      res_valid_o,
    input  logic                      res_ready_i
);
    localparam int RW = row_w(ROWS);
    localparam int PW = plane_w(ACT_W);
    localparam int DW = cnt_w(MAC_LAT + 1);

    logic [2:0]            state, state_nxt;
    logic [RW-1:0]         row_cnt;
    logic [DW-1:0]         drain_cnt;
    logic [NVEC_W-1:0]     vec_cnt, nvec_q;
    logic                  single_q;
    logic [ROWS*ACT_W-1:0] vec_q, vec_src;
    logic [PW-1:0]         plane_nxt;
    logic [ROWS-1:0]       a_bit_nxt;
    logic                  start_acc, w_hs, a_hs, r_hs, last_row, last_drain, last_vec;

    assign w_ready_o   = state == S_LOAD_W;
    assign a_ready_o   = state == S_WAIT_A;
    assign res_valid_o = state == S_RESULT;

    assign start_acc  = start_i && state == S_IDLE;
    assign w_hs       = w_valid_i && w_ready_o;
    assign a_hs       = a_valid_i && a_ready_o;
    assign r_hs       = res_valid_o && res_ready_i;
    assign last_row   = row_cnt == RW'(ROWS - 1);
    assign last_drain = drain_cnt == DW'(MAC_LAT - 1);
    assign last_vec   = single_q || vec_cnt == nvec_q - 1'b1;

    // The first plane is taken straight from the bus since the latch is loading in the same cycle.
    assign plane_nxt = a_hs ? PW'(ACT_W - 1) : plane_o - 1'b1;
    assign vec_src   = a_hs ? a_data_i : vec_q;

    dff #(.WIDTH(ROWS*ACT_W)) u_act (
        .clk(clk), .rst_n_i(rst_n_i), .en_i(a_hs), .d_i(a_data_i), .q_o(vec_q)
    );

    // Top bit flags a zero/one-vector op so the count compare never needs nvec-1 of zero.
    dff #(.WIDTH(NVEC_W+1)) u_cfg (
        .clk(clk), .rst_n_i(rst_n_i), .en_i(start_acc),
        .d_i({cfg_nvec_i == '0, cfg_nvec_i}), .q_o({single_q, nvec_q})
    );

    for (genvar r = 0; r < ROWS; r++) begin : g_bit
        logic [ACT_W-1:0] elem;
        assign elem         = vec_src[r*ACT_W +: ACT_W];
        assign a_bit_nxt[r] = elem[plane_nxt];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_i) state_nxt = reload_w_i ? S_LOAD_W : S_WAIT_A;
            S_LOAD_W:  if (w_hs && last_row) state_nxt = S_WAIT_A;
            S_WAIT_A:  if (a_hs) state_nxt = S_COMPUTE;
            S_COMPUTE: if (plane_o == '0) state_nxt = MAC_LAT > 0 ? S_DRAIN : S_RESULT;
            S_DRAIN:   if (last_drain) state_nxt = S_RESULT;
            S_RESULT:  if (res_ready_i) state_nxt = last_vec ? S_DONE : S_WAIT_A;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            row_cnt     <= '0;
            drain_cnt   <= '0;
            vec_cnt     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            wrow_en_o   <= '0;
            wrow_data_o <= '0;
            cim_en_o    <= 1'b0;
            a_bit_o     <= '0;
            plane_o     <= '0;
            acc_clr_o   <= 1'b0;
            acc_neg_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            row_cnt     <= start_acc ? '0 : w_hs ? (last_row ? '0 : row_cnt + 1'b1) : row_cnt;
            drain_cnt   <= state == S_DRAIN ? drain_cnt + 1'b1 : '0;
            vec_cnt     <= start_acc ? '0 : r_hs ? vec_cnt + 1'b1 : vec_cnt;
            busy_o      <= state_nxt != S_IDLE;
            done_o      <= state_nxt == S_DONE;
            wrow_en_o   <= w_hs ? ROWS'(1) << row_cnt : '0;
            if (w_hs) wrow_data_o <= w_data_i;
            cim_en_o    <= state_nxt == S_COMPUTE;
            plane_o     <= state_nxt == S_COMPUTE ? plane_nxt : '0;
            a_bit_o     <= state_nxt == S_COMPUTE ? a_bit_nxt : '0;
            acc_clr_o   <= a_hs;
            acc_neg_o   <= a_hs;
        end
    end
endmodule

// File: tb/tb_cim_op_seq.sv
// tb_cim_op_seq: scoreboard bench for the CiM operator sequencer; weight-row and
// bit-plane events are predicted at stimulus time and matched against what the DUT emits.
module tb_cim_op_seq;
    localparam int ROWS = 16, COLS = 16, ACT_W = 8, MAC_LAT = 2, NVEC_W = 8;
    localparam int PW  = $clog2(ACT_W);
    localparam int VW  = ROWS*ACT_W;
    localparam int WDW = 2*COLS;
    localparam int PE  = ROWS+PW+2;
    localparam int WE  = ROWS+WDW;

    logic clk = 0, rst_n_i = 0;
    logic start_i = 0, reload_w_i = 0;
    logic [NVEC_W-1:0] cfg_nvec_i = '0;
    logic busy_o, done_o;
    logic w_valid_i = 0, w_ready_o;
    logic [WDW-1:0] w_data_i = '0;
    logic [ROWS-1:0] wrow_en_o;
    logic [WDW-1:0] wrow_data_o;
    logic a_valid_i = 0, a_ready_o;
    logic [VW-1:0] a_data_i = '0;
    logic cim_en_o;
    logic [ROWS-1:0] a_bit_o;
    logic [PW-1:0] plane_o;
    logic acc_clr_o, acc_neg_o, res_valid_o, res_ready_i = 0;
    logic [7+2*ROWS+2*COLS+PW:0] all_out;

    int checks = 0, errors = 0, tmo = 0;
    int res_acc = 0, done_cnt = 0, wrdy_cnt = 0, w_rd = 0, p_rd = 0;
    logic [WE-1:0] w_exp_q[$], w_obs_q[$];
    logic [PE-1:0] p_exp_q[$], p_obs_q[$];

    cim_op_seq #(.ROWS(ROWS), .COLS(COLS), .ACT_W(ACT_W), .MAC_LAT(MAC_LAT), .NVEC_W(NVEC_W)) dut (
        .clk(clk), .rst_n_i(rst_n_i), .start_i(start_i), .reload_w_i(reload_w_i),
        .cfg_nvec_i(cfg_nvec_i), .busy_o(busy_o), .done_o(done_o),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .wrow_en_o(wrow_en_o), .wrow_data_o(wrow_data_o),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
        .cim_en_o(cim_en_o), .a_bit_o(a_bit_o), .plane_o(plane_o),
        .acc_clr_o(acc_clr_o), .acc_neg_o(acc_neg_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i)
    );

    assign all_out = {busy_o, done_o, w_ready_o, wrow_en_o, wrow_data_o, a_ready_o, cim_en_o,
                      a_bit_o, plane_o, acc_clr_o, acc_neg_o, res_valid_o};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrow_en_o != '0) w_obs_q.push_back({wrow_en_o, wrow_data_o});
        if (cim_en_o) p_obs_q.push_back({a_bit_o, plane_o, acc_clr_o, acc_neg_o});
        if (done_o) done_cnt++;
        if (w_ready_o) wrdy_cnt++;
    end

    always @(posedge clk) if (res_valid_o && res_ready_i) res_acc++;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start(input bit rl, input int nv);
        start_i = 1; reload_w_i = rl; cfg_nvec_i = NVEC_W'(nv);
        @(negedge clk);
        start_i = 0;
    endtask

    task automatic load_w(input bit stall, input bit rnd);
        int k = 0, n = 0;
        logic [WDW-1:0] d;
        while (k < ROWS && n < 2000) begin
            d = rnd ? WDW'($urandom) : WDW'(k);
            w_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            w_data_i = d;
            if (w_valid_i && w_ready_o) begin
                w_exp_q.push_back({ROWS'(1) << k, d});
                k++;
            end
            @(negedge clk);
            n++;
        end
        w_valid_i = 0;
        if (k < ROWS) tmo++;
    endtask

    task automatic send_vec(input logic [VW-1:0] v);
        int n = 0;
        logic [ROWS-1:0] b;
        a_data_i = v; a_valid_i = 1;
        while (!a_ready_o && n < 200) begin @(negedge clk); n++; end
        if (!a_ready_o) tmo++;
        else for (int p = ACT_W-1; p >= 0; p--) begin
            for (int r = 0; r < ROWS; r++) b[r] = v[r*ACT_W+p];
            p_exp_q.push_back({b, PW'(p), p == ACT_W-1, p == ACT_W-1});
        end
        @(negedge clk);
        a_valid_i = 0;
    endtask

    task automatic take_result(input int hold);
        int n = 0;
        while (!res_valid_o && n < 100) begin @(negedge clk); n++; end
        if (!res_valid_o) tmo++;
        repeat (hold) @(negedge clk);
        res_ready_i = 1;
        @(negedge clk);
        res_ready_i = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 200) begin @(negedge clk); n++; end
        if (!done_o) tmo++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all_out); end
        rst_n_i = 1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_idle got %h exp 0", all_out); end
    endtask

    task automatic test_load_weights();
        logic [WE-1:0] we, wo;
        do_start(1, 1);
        checks++;
        if ({busy_o, w_ready_o, a_ready_o} !== 3'b110) begin
            errors++; $display("FAIL load_entry got %b exp 110", {busy_o, w_ready_o, a_ready_o});
        end
        load_w(0, 0);
        @(negedge clk);
        while (w_exp_q.size() != 0) begin
            we = w_exp_q.pop_front();
            wo = w_rd < w_obs_q.size() ? w_obs_q[w_rd] : 'x;
            w_rd++;
            checks++;
            if (wo !== we) begin errors++; $display("FAIL load_wrow got %h exp %h", wo, we); end
        end
        checks++;
        if (w_obs_q.size() !== w_rd) begin errors++; $display("FAIL load_wrow_count got %0d exp %0d", w_obs_q.size(), w_rd); end
        w_rd = w_obs_q.size();
        checks++;
        if (a_ready_o !== 1'b1) begin errors++; $display("FAIL load_to_wait_a got %b exp 1", a_ready_o); end
        checks++;
        if (tmo !== 0) begin errors++; $display("FAIL load_timeout got %0d exp 0", tmo); tmo = 0; end
    endtask

    task automatic test_msb_vector();
        logic [VW-1:0] v;
        logic [PE-1:0] pe, po;
        v = '0;
        v[7:0] = 8'h80;
        send_vec(v);
        repeat (9) @(negedge clk);
        checks++;
        if (res_valid_o !== 1'b0) begin errors++; $display("FAIL msb_early got %b exp 0", res_valid_o); end
        @(negedge clk);
        checks++;
        if (res_valid_o !== 1'b1) begin errors++; $display("FAIL msb_latency got %b exp 1", res_valid_o); end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (res_valid_o !== 1'b1) begin errors++; $display("FAIL msb_hold got %b exp 1", res_valid_o); end
        end
        res_ready_i = 1;
        @(negedge clk);
        res_ready_i = 0;
        checks++;
        if ({done_o, busy_o, res_valid_o} !== 3'b110) begin
            errors++; $display("FAIL msb_done got %b exp 110", {done_o, busy_o, res_valid_o});
        end
        @(negedge clk);
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin errors++; $display("FAIL msb_idle got %b exp 00", {done_o, busy_o}); end
        while (p_exp_q.size() != 0) begin
            pe = p_exp_q.pop_front();
            po = p_rd < p_obs_q.size() ? p_obs_q[p_rd] : 'x;
            p_rd++;
            checks++;
            if (po !== pe) begin errors++; $display("FAIL msb_plane got %h exp %h", po, pe); end
        end
        checks++;
        if (p_obs_q.size() !== p_rd) begin errors++; $display("FAIL msb_plane_count got %0d exp %0d", p_obs_q.size(), p_rd); end
        p_rd = p_obs_q.size();
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt, r0 = res_acc, wr0 = wrdy_cnt, wo0 = w_obs_q.size();
        logic [PE-1:0] pe, po;
        do_start(0, 3);
        checks++;
        if ({busy_o, w_ready_o, a_ready_o} !== 3'b101) begin
            errors++; $display("FAIL b2b_entry got %b exp 101", {busy_o, w_ready_o, a_ready_o});
        end
        res_ready_i = 1;
        for (int i = 0; i < 3; i++) send_vec({$urandom, $urandom, $urandom, $urandom});
        wait_done();
        res_ready_i = 0;
        checks++;
        if (res_acc - r0 !== 3) begin errors++; $display("FAIL b2b_results got %0d exp 3", res_acc - r0); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL b2b_done got %0d exp 1", done_cnt - d0); end
        checks++;
        if (wrdy_cnt - wr0 !== 0 || w_obs_q.size() - wo0 !== 0) begin
            errors++; $display("FAIL b2b_no_weights got %0d/%0d exp 0/0", wrdy_cnt - wr0, w_obs_q.size() - wo0);
        end
        while (p_exp_q.size() != 0) begin
            pe = p_exp_q.pop_front();
            po = p_rd < p_obs_q.size() ? p_obs_q[p_rd] : 'x;
            p_rd++;
            checks++;
            if (po !== pe) begin errors++; $display("FAIL b2b_plane got %h exp %h", po, pe); end
        end
        checks++;
        if (p_obs_q.size() !== p_rd) begin errors++; $display("FAIL b2b_plane_count got %0d exp %0d", p_obs_q.size(), p_rd); end
        p_rd = p_obs_q.size();
        checks++;
        if (tmo !== 0) begin errors++; $display("FAIL b2b_timeout got %0d exp 0", tmo); tmo = 0; end
    endtask

    task automatic test_nvec_zero();
        int d0 = done_cnt, r0 = res_acc;
        logic [PE-1:0] pe, po;
        do_start(0, 0);
        start_i = 1; reload_w_i = 1; cfg_nvec_i = 8'd5;
        @(negedge clk);
        start_i = 0;
        checks++;
        if ({w_ready_o, a_ready_o} !== 2'b01) begin
            errors++; $display("FAIL nvec0_busy_start got %b exp 01", {w_ready_o, a_ready_o});
        end
        send_vec({$urandom, $urandom, $urandom, $urandom});
        take_result(0);
        checks++;
        if (done_o !== 1'b1) begin errors++; $display("FAIL nvec0_done got %b exp 1", done_o); end
        start_i = 1;
        @(negedge clk);
        start_i = 0; reload_w_i = 0;
        checks++;
        if ({busy_o, w_ready_o, a_ready_o} !== 3'b000) begin
            errors++; $display("FAIL nvec0_start_in_done got %b exp 000", {busy_o, w_ready_o, a_ready_o});
        end
        @(negedge clk);
        checks++;
        if (res_acc - r0 !== 1 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL nvec0_count got %0d/%0d exp 1/1", res_acc - r0, done_cnt - d0);
        end
        while (p_exp_q.size() != 0) begin
            pe = p_exp_q.pop_front();
            po = p_rd < p_obs_q.size() ? p_obs_q[p_rd] : 'x;
            p_rd++;
            checks++;
            if (po !== pe) begin errors++; $display("FAIL nvec0_plane got %h exp %h", po, pe); end
        end
        checks++;
        if (p_obs_q.size() !== p_rd) begin errors++; $display("FAIL nvec0_plane_count got %0d exp %0d", p_obs_q.size(), p_rd); end
        p_rd = p_obs_q.size();
        checks++;
        if (tmo !== 0) begin errors++; $display("FAIL nvec0_timeout got %0d exp 0", tmo); tmo = 0; end
    endtask

    task automatic test_stall_load();
        logic [WE-1:0] we, wo;
        logic [PE-1:0] pe, po;
        do_start(1, 1);
        load_w(1, 1);
        @(negedge clk);
        while (w_exp_q.size() != 0) begin
            we = w_exp_q.pop_front();
            wo = w_rd < w_obs_q.size() ? w_obs_q[w_rd] : 'x;
            w_rd++;
            checks++;
            if (wo !== we) begin errors++; $display("FAIL stall_wrow got %h exp %h", wo, we); end
        end
        checks++;
        if (w_obs_q.size() !== w_rd) begin errors++; $display("FAIL stall_wrow_count got %0d exp %0d", w_obs_q.size(), w_rd); end
        w_rd = w_obs_q.size();
        send_vec({$urandom, $urandom, $urandom, $urandom});
        take_result(2);
        @(negedge clk);
        while (p_exp_q.size() != 0) begin
            pe = p_exp_q.pop_front();
            po = p_rd < p_obs_q.size() ? p_obs_q[p_rd] : 'x;
            p_rd++;
            checks++;
            if (po !== pe) begin errors++; $display("FAIL stall_plane got %h exp %h", po, pe); end
        end
        checks++;
        if (p_obs_q.size() !== p_rd) begin errors++; $display("FAIL stall_plane_count got %0d exp %0d", p_obs_q.size(), p_rd); end
        p_rd = p_obs_q.size();
        checks++;
        if (tmo !== 0) begin errors++; $display("FAIL stall_timeout got %0d exp 0", tmo); tmo = 0; end
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        logic [PE-1:0] pe, po;
        do_start(0, 1);
        send_vec({$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        rst_n_i = 0;
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL rstmid_outputs got %h exp 0", all_out); end
        @(negedge clk);
        rst_n_i = 1;
        p_exp_q.delete();
        p_rd = p_obs_q.size();
        checks++;
        if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", done_cnt - d0); end
        do_start(0, 1);
        send_vec({$urandom, $urandom, $urandom, $urandom});
        take_result(0);
        @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_done got %0d exp 1", done_cnt - d0); end
        while (p_exp_q.size() != 0) begin
            pe = p_exp_q.pop_front();
            po = p_rd < p_obs_q.size() ? p_obs_q[p_rd] : 'x;
            p_rd++;
            checks++;
            if (po !== pe) begin errors++; $display("FAIL rstmid_plane got %h exp %h", po, pe); end
        end
        checks++;
        if (p_obs_q.size() !== p_rd) begin errors++; $display("FAIL rstmid_plane_count got %0d exp %0d", p_obs_q.size(), p_rd); end
        checks++;
        if (tmo !== 0) begin errors++; $display("FAIL rstmid_timeout got %0d exp 0", tmo); tmo = 0; end
    endtask

    initial begin
        test_reset();
        test_load_weights();
        test_msb_vector();
        test_back_to_back();
        test_nvec_zero();
        test_stall_load();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
